// File: rtl/frac_lut_cfg_pkg.sv
// Shared definitions for the fracturable configurable LUT.
//  - Control-bit offsets above the truth table inside the config register.
//  - Lookup mode encoding.
//  - Helpers deriving the config register length and full-load shift count.
package frac_lut_cfg_pkg;

  // Control bits sit directly above the truth table: cfg[MEM_SIZE + offset].
  localparam int unsigned FRAC_BIT   = 0;
  localparam int unsigned REG_EN_BIT = 1;
  localparam int unsigned CTRL_BITS  = 2;

  typedef enum logic {
    MODE_FULL = 1'b0,  // one k-input LUT
    MODE_FRAC = 1'b1   // two (k-1)-input LUTs sharing the low inputs
  } lut_mode_e;

  // Table plus control bits, rounded up to a whole number of chain words.
  function automatic int unsigned cfg_len_f(input int unsigned mem_size,
                                            input int unsigned cw);
    return ((mem_size + CTRL_BITS + cw - 1) / cw) * cw;
  endfunction

  function automatic int unsigned load_cycles_f(input int unsigned mem_size,
                                                input int unsigned cw);
    return cfg_len_f(mem_size, cw) / cw;
  endfunction

endpackage

// File: rtl/frac_lut_cfg_shift_chain.sv
// cfg_shift_chain: configuration shift register with a saturating load counter.
// Ports:
//  clk, rst      clock, synchronous active-high reset
//  config_en     shift enable
//  config_in     CONFIG_WIDTH-bit chain input (enters at the bottom)
//  cfg_reg       full configuration register contents
//  config_out    top CONFIG_WIDTH bits of cfg_reg (chain output, no extra stage)
//  config_done   high once LOAD_CYCLES shifts have happened since reset
module cfg_shift_chain #(
  parameter int unsigned CFG_LEN      = 34,
  parameter int unsigned CONFIG_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    config_en,
  input  logic [CONFIG_WIDTH-1:0] config_in,
  output logic [CFG_LEN-1:0]      cfg_reg,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_done
);

  localparam int unsigned LOAD_CYCLES = CFG_LEN / CONFIG_WIDTH;
  localparam int unsigned CNT_W       = $clog2(LOAD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOAD_CYCLES);

  logic [CNT_W-1:0]   count;
  logic [CFG_LEN-1:0] cfg_next;

  generate
    if (CFG_LEN > CONFIG_WIDTH) begin : g_shift
      assign cfg_next = {cfg_reg[CFG_LEN-CONFIG_WIDTH-1:0], config_in};
    end else begin : g_single_word
      assign cfg_next = config_in;
    end
  endgenerate

  // Shifting continues after saturation so downstream instances keep loading.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_reg <= '0;
      count   <= '0;
    end else if (config_en) begin
      cfg_reg <= cfg_next;
      if (count != CNT_MAX) count <= count + CNT_W'(1);
    end
  end

  assign config_out  = cfg_reg[CFG_LEN-1 -: CONFIG_WIDTH];
  assign config_done = (count == CNT_MAX);

endmodule

// File: rtl/frac_lut_cfg.sv
// frac_lut_cfg: fracturable LUT with a shift-chain-loaded truth table and an
// optional output register.
// Ports:
//  clk, rst      clock, synchronous active-high reset
//  config_en     config chain shift enable
//  config_in     chain input from the previous LUT / CLB loader
//  config_out    chain output to the next LUT
//  config_done   full load completed
//  addr          LUT inputs
//  out           out[0] main / low-half result, out[1] high-half result (frac mode)
module frac_lut_cfg
  import frac_lut_cfg_pkg::*;
#(
  parameter int unsigned INPUTS       = 5,
  parameter int unsigned CONFIG_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    config_en,
  input  logic [CONFIG_WIDTH-1:0] config_in,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_done,
  input  logic [INPUTS-1:0]       addr,
  output logic [1:0]              out
);

  localparam int unsigned MEM_SIZE = 2 ** INPUTS;
  localparam int unsigned CFG_LEN  = cfg_len_f(MEM_SIZE, CONFIG_WIDTH);

  logic [CFG_LEN-1:0]  cfg_reg;
  logic [MEM_SIZE-1:0] lut_tbl;
  lut_mode_e           mode;
  logic                reg_en;
  logic                gate;
  logic [INPUTS-1:0]   lo_idx;
  logic [INPUTS-1:0]   hi_idx;
  logic [1:0]          r;
  logic [1:0]          out_q;

  cfg_shift_chain #(
    .CFG_LEN      (CFG_LEN),
    .CONFIG_WIDTH (CONFIG_WIDTH)
  ) u_chain (
    .clk         (clk),
    .rst         (rst),
    .config_en   (config_en),
    .config_in   (config_in),
    .cfg_reg     (cfg_reg),
    .config_out  (config_out),
    .config_done (config_done)
  );

  assign lut_tbl = cfg_reg[MEM_SIZE-1:0];
  assign mode    = lut_mode_e'(cfg_reg[MEM_SIZE + FRAC_BIT]);
  assign reg_en  = cfg_reg[MEM_SIZE + REG_EN_BIT];

  // Padding bits only travel along the chain; they carry no function here.
  generate
    if (CFG_LEN > MEM_SIZE + CTRL_BITS) begin : g_pad
      logic pad_unused;
      assign pad_unused = ^cfg_reg[CFG_LEN-1:MEM_SIZE+CTRL_BITS];
    end
  endgenerate

  // Outputs stay quiet while loading or before a complete load.
  assign gate   = config_en | ~config_done;
  assign lo_idx = {1'b0, addr[INPUTS-2:0]};
  assign hi_idx = {1'b1, addr[INPUTS-2:0]};

  always_comb begin
    r = '0;
    if (!gate) begin
      unique case (mode)
        MODE_FULL: r[0] = lut_tbl[addr];
        MODE_FRAC: begin
          r[0] = lut_tbl[lo_idx];
          r[1] = lut_tbl[hi_idx];
        end
        default: r = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || config_en) out_q <= '0;
    else                  out_q <= r;
  end

  assign out = reg_en ? out_q : r;

endmodule

// File: tb/tb_frac_lut_cfg.sv
module tb_frac_lut_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [0:0] cin = '0;
  logic [3:0] addr4 = '0;
  logic [0:0] cout0, cout1;
  logic       done0, done1;
  logic [1:0] out0, out1;

  logic       en2 = 1'b0;
  logic [1:0] cin2 = '0;
  logic [4:0] addr5 = '0;
  logic [1:0] cout2;
  logic       done2;
  logic [1:0] out2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Chain head (inst0) feeds inst1.
  frac_lut_cfg #(.INPUTS(4), .CONFIG_WIDTH(1)) dut0 (
    .clk(clk), .rst(rst), .config_en(en), .config_in(cin),
    .config_out(cout0), .config_done(done0), .addr(addr4), .out(out0));

  frac_lut_cfg #(.INPUTS(4), .CONFIG_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .config_en(en), .config_in(cout0),
    .config_out(cout1), .config_done(done1), .addr(addr4), .out(out1));

  frac_lut_cfg #(.INPUTS(5), .CONFIG_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .config_en(en2), .config_in(cin2),
    .config_out(cout2), .config_done(done2), .addr(addr5), .out(out2));

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic shift1(input logic b);
    en = 1'b1;
    cin = b;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done0); end
    checks++; if (out0 !== 2'b00) begin errors++; $display("FAIL reset_out got %b want 00", out0); end
    checks++; if (cout0 !== 1'b0) begin errors++; $display("FAIL reset_cfg_out got %b want 0", cout0); end
  endtask

  // Single-output 4-input AND, comb output.
  task automatic test_full_lut();
    logic [17:0] v;
    logic [1:0]  exp;
    v = 18'h08000;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      shift1(v[17-i]);
      if (i == 16) begin
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL t1_done_at17 got %b want 0", done0); end
      end
    end
    en = 1'b0;
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL t1_done_at18 got %b want 1", done0); end
    checks++; if (cout0 !== 1'b0) begin errors++; $display("FAIL t1_cfg_out got %b want 0", cout0); end
    for (int a = 0; a < 16; a++) begin
      addr4 = 4'(a);
      #1;
      exp = (a == 15) ? 2'b01 : 2'b00;
      checks++; if (out0 !== exp) begin errors++; $display("FAIL t1_out addr=%0d got %b want %b", a, out0, exp); end
    end
  endtask

  // Frac mode: high half XOR3, low half MAJ3.
  task automatic test_frac();
    logic [17:0] v;
    logic [7:0]  lo_tt, hi_tt;
    logic [1:0]  exp;
    v = 18'h196E8;
    lo_tt = 8'hE8;
    hi_tt = 8'h96;
    do_reset();
    for (int i = 0; i < 18; i++) shift1(v[17-i]);
    en = 1'b0;
    addr4 = 4'b0011; #1;
    checks++; if (out0 !== 2'b01) begin errors++; $display("FAIL t2_addr011 got %b want 01", out0); end
    addr4 = 4'b0111; #1;
    checks++; if (out0 !== 2'b11) begin errors++; $display("FAIL t2_addr111 got %b want 11", out0); end
    addr4 = 4'b0001; #1;
    checks++; if (out0 !== 2'b10) begin errors++; $display("FAIL t2_addr001 got %b want 10", out0); end
    for (int a = 0; a < 16; a++) begin
      addr4 = 4'(a);
      #1;
      exp = {hi_tt[a%8], lo_tt[a%8]};
      checks++; if (out0 !== exp) begin errors++; $display("FAIL t2_out addr=%0d got %b want %b", a, out0, exp); end
    end
  endtask

  // Registered output: zero during load, one-clock latency afterwards.
  task automatic test_reg_out();
    logic [17:0] v;
    v = 18'h2FFFF;
    addr4 = 4'h0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      shift1(v[17-i]);
      checks++; if (out0 !== 2'b00) begin errors++; $display("FAIL t3_out_loading shift=%0d got %b want 00", i, out0); end
    end
    en = 1'b0;
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL t3_done got %b want 1", done0); end
    checks++; if (cout0 !== 1'b1) begin errors++; $display("FAIL t3_cfg_out got %b want 1", cout0); end
    checks++; if (out0 !== 2'b00) begin errors++; $display("FAIL t3_out_before_edge got %b want 00", out0); end
    @(posedge clk); #1;
    checks++; if (out0 !== 2'b01) begin errors++; $display("FAIL t3_out_after_edge got %b want 01", out0); end
    // Same mode with an AND4 table so an addr change is observable.
    v = 18'h28000;
    do_reset();
    for (int i = 0; i < 18; i++) shift1(v[17-i]);
    en = 1'b0;
    addr4 = 4'hF;
    @(posedge clk); #1;
    checks++; if (out0 !== 2'b01) begin errors++; $display("FAIL t3_and_F got %b want 01", out0); end
    addr4 = 4'h0; #1;
    checks++; if (out0 !== 2'b01) begin errors++; $display("FAIL t3_latency_hold got %b want 01", out0); end
    @(posedge clk); #1;
    checks++; if (out0 !== 2'b00) begin errors++; $display("FAIL t3_latency_update got %b want 00", out0); end
  endtask

  // Two chained instances: inst1 (OR4) bits first, then inst0 (AND4).
  task automatic test_chain();
    logic [17:0] v0, v1;
    logic [1:0]  e0, e1;
    v1 = 18'h0FFFE;
    v0 = 18'h08000;
    do_reset();
    for (int i = 0; i < 18; i++) shift1(v1[17-i]);
    for (int i = 0; i < 18; i++) shift1(v0[17-i]);
    en = 1'b0;
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL t4_done0 got %b want 1", done0); end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL t4_done1 got %b want 1", done1); end
    for (int a = 0; a < 16; a++) begin
      addr4 = 4'(a);
      #1;
      e0 = (a == 15) ? 2'b01 : 2'b00;
      e1 = (a != 0)  ? 2'b01 : 2'b00;
      checks++; if (out0 !== e0) begin errors++; $display("FAIL t4_and4 addr=%0d got %b want %b", a, out0, e0); end
      checks++; if (out1 !== e1) begin errors++; $display("FAIL t4_or4 addr=%0d got %b want %b", a, out1, e1); end
    end
  endtask

  // Reset mid-load, with config_en held high during the reset cycle.
  task automatic test_reset_mid_load();
    logic [17:0] v;
    do_reset();
    for (int i = 0; i < 7; i++) shift1(1'b1);
    rst = 1'b1; en = 1'b1; cin = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
    addr4 = 4'hF; #1;
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL t5_done_after_rst got %b want 0", done0); end
    checks++; if (out0 !== 2'b00) begin errors++; $display("FAIL t5_out_after_rst got %b want 00", out0); end
    v = 18'h08000;
    for (int i = 0; i < 18; i++) begin
      shift1(v[17-i]);
      if (i == 16) begin
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL t5_done_at17 got %b want 0", done0); end
      end
    end
    en = 1'b0;
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL t5_done_at18 got %b want 1", done0); end
    addr4 = 4'hF; #1;
    checks++; if (out0 !== 2'b01) begin errors++; $display("FAIL t5_addrF got %b want 01", out0); end
    addr4 = 4'h7; #1;
    checks++; if (out0 !== 2'b00) begin errors++; $display("FAIL t5_addr7 got %b want 00", out0); end
  endtask

  // INPUTS=5, CONFIG_WIDTH=2: 17 two-bit words, 5-input parity table.
  task automatic test_wide_chain();
    logic [33:0] v;
    logic [1:0]  exp;
    v = {2'b00, 32'h9669_6996};
    do_reset();
    for (int k = 0; k < 17; k++) begin
      en2 = 1'b1;
      cin2 = v[33 - 2*k -: 2];
      @(posedge clk); #1;
      if (k == 15) begin
        checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL t6_done_at16 got %b want 0", done2); end
      end
    end
    en2 = 1'b0;
    checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL t6_done_at17 got %b want 1", done2); end
    for (int a = 0; a < 32; a++) begin
      logic [4:0] av;
      av = 5'(a);
      addr5 = av;
      #1;
      exp = {1'b0, ^av};
      checks++; if (out2 !== exp) begin errors++; $display("FAIL t6_parity addr=%0d got %b want %b", a, out2, exp); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_lut();
    test_frac();
    test_reg_out();
    test_chain();
    test_reset_mid_load();
    test_wide_chain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
